// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - shares one AES S-box between the round datapath and key expansion

// sbox.sv - combinational AES forward S-box lookup
module sbox (
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // Entry i sits at bits [2047-8i -: 8], so the table reads in natural row order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_idx;

    // Convert the byte address into the MSB position of its table entry.
    always_comb begin
        bit_idx = 11'd2047 - {addr, 3'b000};
    end

    assign data = SBOX_TABLE[bit_idx -: 8];

endmodule

// sbox_sched - arbitrates and serialises SubBytes / SubWord requests onto one S-box
module sbox_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_valid,
    input  logic [127:0] st_data,
    output logic         st_ready,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         kw_valid,
    input  logic [31:0]  kw_data,
    output logic         kw_ready,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           last_kw_q, last_kw_d;
    logic [127:0]   st_result_q, st_result_d;
    logic [31:0]    kw_result_q, kw_result_d;
    logic           st_done_q, st_done_d;
    logic           kw_done_q, kw_done_d;

    logic           grant_st;
    logic           grant_kw;
    logic [6:0]     byte_sel;
    logic [7:0]     sbox_in;
    logic [7:0]     sbox_out;

    // The single shared lookup; its address is always the byte under the counter.
    sbox u_sbox (
        .addr (sbox_in),
        .data (sbox_out)
    );

    // Tie-break: round-robin hands the tie to whoever was not served last,
    // fixed priority always hands it to the key path.
    always_comb begin
        grant_st = st_valid && (!kw_valid || (RR_EN && last_kw_q));
        grant_kw = kw_valid && !grant_st;
        st_ready = (state_q == IDLE) && grant_st;
        kw_ready = (state_q == IDLE) && grant_kw;
        byte_sel = {cnt_q, 3'b000};
        sbox_in  = work_q[byte_sel +: 8];
    end

    // Next-state logic: accept in IDLE, then substitute one byte per clock.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        last_kw_d   = last_kw_q;
        st_result_d = st_result_q;
        kw_result_d = kw_result_q;
        st_done_d   = 1'b0;
        kw_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_ready) begin
                    work_d    = st_data;
                    cnt_d     = 4'd0;
                    last_kw_d = 1'b0;
                    state_d   = ST_RUN;
                end else if (kw_ready) begin
                    work_d    = {96'd0, kw_data};
                    cnt_d     = 4'd0;
                    last_kw_d = 1'b1;
                    state_d   = KW_RUN;
                end
            end
            ST_RUN: begin
                work_d[byte_sel +: 8] = sbox_out;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    st_result_d = work_d;
                    st_done_d   = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = IDLE;
                end
            end
            KW_RUN: begin
                work_d[byte_sel +: 8] = sbox_out;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    kw_result_d = work_d[31:0];
                    kw_done_d   = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // All state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            last_kw_q   <= 1'b0;
            st_result_q <= '0;
            kw_result_q <= '0;
            st_done_q   <= 1'b0;
            kw_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            last_kw_q   <= last_kw_d;
            st_result_q <= st_result_d;
            kw_result_q <= kw_result_d;
            st_done_q   <= st_done_d;
            kw_done_q   <= kw_done_d;
        end
    end

    assign st_done   = st_done_q;
    assign kw_done   = kw_done_q;
    assign st_result = st_result_q;
    assign kw_result = kw_result_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - directed self-checking bench for sbox_sched
module tb_sbox_sched;

    logic         clk = 1'b0;
    logic         reset;

    logic         st_valid, kw_valid;
    logic [127:0] st_data;
    logic [31:0]  kw_data;
    logic         st_ready, st_done, kw_ready, kw_done, busy;
    logic [127:0] st_result;
    logic [31:0]  kw_result;

    logic         fp_st_valid, fp_kw_valid;
    logic [127:0] fp_st_data;
    logic [31:0]  fp_kw_data;
    logic         fp_st_ready, fp_st_done, fp_kw_ready, fp_kw_done, fp_busy;
    logic [127:0] fp_st_result;
    logic [31:0]  fp_kw_result;

    int checks = 0;
    int errors = 0;
    int cyc, busy_cnt, other_done;

    localparam logic [127:0] ST_ZERO_RES  = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ST_SEQ_DATA  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ST_SEQ_RES   = 128'h637c777bf26b6fc53001672bfed7ab76;

    always #5 clk = ~clk;

    sbox_sched #(.RR_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .st_done   (st_done),
        .st_result (st_result),
        .kw_valid  (kw_valid),
        .kw_data   (kw_data),
        .kw_ready  (kw_ready),
        .kw_done   (kw_done),
        .kw_result (kw_result),
        .busy      (busy)
    );

    sbox_sched #(.RR_EN(1'b0)) dut_fp (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (fp_st_valid),
        .st_data   (fp_st_data),
        .st_ready  (fp_st_ready),
        .st_done   (fp_st_done),
        .st_result (fp_st_result),
        .kw_valid  (fp_kw_valid),
        .kw_data   (fp_kw_data),
        .kw_ready  (fp_kw_ready),
        .kw_done   (fp_kw_done),
        .kw_result (fp_kw_result),
        .busy      (fp_busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accept edge (cycle 1); returns the cycle in which done was seen.
    task automatic wait_done(input bit for_kw, output int c, output int b, output int o);
        c = 1;
        b = 0;
        o = 0;
        while (((for_kw ? kw_done : st_done) !== 1'b1) && c < 40) begin
            if (busy === 1'b1) b++;
            if ((for_kw ? st_done : kw_done) === 1'b1) o++;
            tick();
            c++;
        end
    endtask

    initial begin
        reset = 1'b1;
        st_valid = 1'b0; kw_valid = 1'b0; st_data = '0; kw_data = '0;
        fp_st_valid = 1'b0; fp_kw_valid = 1'b0; fp_st_data = '0; fp_kw_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rst_st_result", st_result, 128'd0);
        check("rst_kw_result", {96'd0, kw_result}, 128'd0);
        check("rst_st_done", {127'd0, st_done}, 128'd0);
        check("rst_kw_done", {127'd0, kw_done}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_ready_idle", {126'd0, st_ready, kw_ready}, 128'd0);

        // Zero state block
        st_valid = 1'b1; st_data = '0;
        #1;
        check("zero_st_ready", {126'd0, st_ready, kw_ready}, 128'd2);
        tick();
        st_valid = 1'b0;
        check("zero_busy_c1", {127'd0, busy}, 128'd1);
        wait_done(1'b0, cyc, busy_cnt, other_done);
        check("zero_done_cycle", 128'(cyc), 128'd17);
        check("zero_result", st_result, ST_ZERO_RES);
        check("zero_no_kw_done", 128'(other_done), 128'd0);
        check("zero_busy_cycles", 128'(busy_cnt), 128'd16);
        check("zero_busy_in_done", {127'd0, busy}, 128'd0);
        tick();
        check("zero_done_pulse", {127'd0, st_done}, 128'd0);

        // Byte order
        st_valid = 1'b1; st_data = ST_SEQ_DATA;
        tick();
        st_valid = 1'b0;
        wait_done(1'b0, cyc, busy_cnt, other_done);
        check("seq_done_cycle", 128'(cyc), 128'd17);
        check("seq_result", st_result, ST_SEQ_RES);

        // Key word
        kw_valid = 1'b1; kw_data = 32'hcf4f3c09;
        #1;
        check("kw_ready", {126'd0, st_ready, kw_ready}, 128'd1);
        tick();
        kw_valid = 1'b0;
        wait_done(1'b1, cyc, busy_cnt, other_done);
        check("kw_done_cycle", 128'(cyc), 128'd5);
        check("kw_result", {96'd0, kw_result}, {96'd0, 32'h8a84eb01});
        check("kw_busy_cycles", 128'(busy_cnt), 128'd4);
        check("kw_keeps_st_result", st_result, ST_SEQ_RES);

        // Round-robin tie after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        st_valid = 1'b1; kw_valid = 1'b1; st_data = '0; kw_data = '0;
        #1;
        check("rr_first_grant", {126'd0, st_ready, kw_ready}, 128'd1);
        tick();
        wait_done(1'b1, cyc, busy_cnt, other_done);
        check("rr_kw_done_cycle", 128'(cyc), 128'd5);
        check("rr_kw_result", {96'd0, kw_result}, {96'd0, 32'h63636363});
        check("rr_second_grant", {126'd0, st_ready, kw_ready}, 128'd2);
        tick();
        wait_done(1'b0, cyc, busy_cnt, other_done);
        check("rr_st_done_cycle", 128'(cyc), 128'd17);
        check("rr_st_result", st_result, ST_ZERO_RES);
        check("rr_kw_result_held", {96'd0, kw_result}, {96'd0, 32'h63636363});
        check("rr_third_grant", {126'd0, st_ready, kw_ready}, 128'd1);
        tick();
        st_valid = 1'b0; kw_valid = 1'b0;
        wait_done(1'b1, cyc, busy_cnt, other_done);
        check("rr_third_done", 128'(cyc), 128'd5);

        // Fixed priority: key wins every tie
        fp_st_valid = 1'b1; fp_kw_valid = 1'b1; fp_kw_data = 32'hcf4f3c09;
        #1;
        check("fp_first_grant", {126'd0, fp_st_ready, fp_kw_ready}, 128'd1);
        tick();
        repeat (4) tick();
        check("fp_kw_done", {127'd0, fp_kw_done}, 128'd1);
        check("fp_kw_result", {96'd0, fp_kw_result}, {96'd0, 32'h8a84eb01});
        check("fp_second_grant", {126'd0, fp_st_ready, fp_kw_ready}, 128'd1);
        fp_st_valid = 1'b0; fp_kw_valid = 1'b0;

        // Reset mid-run at counter 7
        st_valid = 1'b1; st_data = ST_SEQ_DATA;
        tick();
        repeat (7) tick();
        check("mid_busy_before", {127'd0, busy}, 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_no_done", {127'd0, st_done}, 128'd0);
        check("mid_result_clear", st_result, 128'd0);
        check("mid_busy", {127'd0, busy}, 128'd0);
        check("mid_reaccept_ready", {126'd0, st_ready, kw_ready}, 128'd2);
        tick();
        check("mid_busy_after", {127'd0, busy}, 128'd1);
        st_valid = 1'b0;

        // Data changes during the run are ignored
        st_data = '0;
        wait_done(1'b0, cyc, busy_cnt, other_done);
        check("stable_done_cycle", 128'(cyc), 128'd17);
        check("stable_result", st_result, ST_SEQ_RES);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Time-shares one combinational `sbox` instance between two requesters:
  - the round datapath (SubBytes, 16 bytes per request);
  - the key-expansion path (SubWord, 4 bytes per request).
- Each accepted request is substituted one byte per clock.
- The finished word is returned with a one-cycle done pulse.
- Sits between the round controller / key scheduler and the shared S-box, so one LUT serves the whole core.

Parameters:
- RR_EN, 1, arbitration mode. 1 = round-robin between requesters. 0 = fixed priority, key path always wins a tie.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- st_valid  input  1  state requester has a 128-bit block to substitute
- st_data  input  128  state block; byte i = st_data[8i+7:8i]
- st_ready  output  1  state request accepted at this clock edge when st_valid && st_ready
- st_done  output  1  one-cycle pulse: st_result updated
- st_result  output  128  substituted block; byte i = S(st_data byte i)
- kw_valid  input  1  key path has a 32-bit word to substitute
- kw_data  input  32  key word; byte i = kw_data[8i+7:8i]
- kw_ready  output  1  key request accepted when kw_valid && kw_ready
- kw_done  output  1  one-cycle pulse: kw_result updated
- kw_result  output  32  substituted word
- busy  output  1  high while a substitution is in progress (not IDLE)

Behaviour:
- Clocking and reset: one clock, clk; reset synchronous active-high.
- Reset values: st_result = 0, kw_result = 0, st_done = 0, kw_done = 0, busy = 0, state = IDLE, byte counter = 0, last_grant = ST.
  - Consequence: the first round-robin tie after reset goes to the key path.
- States:
  - IDLE: accept a request. Working register <- request data, counter <- 0, record owner. Go to ST_RUN or KW_RUN.
  - ST_RUN: each cycle, sbox address = working byte[counter]. The sbox output is written into working byte[counter] at the edge; counter increments.
    - After the edge writing byte 15: st_result <- working register (with byte 15 substituted), st_done <- 1 for one cycle, go to IDLE.
  - KW_RUN: same sequence over bytes 0..3. After byte 3: kw_result updated, kw_done pulses, go to IDLE.
- Arbitration (combinational, only in IDLE):
  - A ready is never asserted unless its valid is high. At most one ready is high per cycle.
  - Only one valid high: that requester gets ready.
  - Both valid, RR_EN = 1: grant the requester that is not last_grant. last_grant updates on accept.
  - Both valid, RR_EN = 0: grant the key path.
- Latency, counted from the accept edge E0:
  - Bytes are written at E1..EN (N = 16 state, N = 4 key).
  - done is high and the result is valid in the cycle after EN. That cycle is IDLE, so a new request can be accepted at the next edge.
- Back-to-back throughput: one request per N+1 cycles.
- Results hold until the same requester's next completion. The other requester's completion does not disturb them.
- Inputs are sampled only at the accept edge. Changes to data during RUN are ignored.
- Valid deasserted without acceptance: no effect.
- Reset mid-operation:
  - The operation is aborted; no done pulse is produced.
  - Results clear to 0.
  - Requesters must re-issue; a request held valid is accepted at the first edge after reset deasserts.
- busy = (state != IDLE). It is low in the done cycle.
- Counter: 4 bits; no wrap beyond 15 occurs, because the state returns to IDLE.

Test Plan:
- Zero state block: reset, then st_valid with st_data = 0.
  - Expect st_ready high in the same cycle.
  - Expect st_done exactly in the 17th cycle after acceptance, with st_result = 128'h63636363636363636363636363636363.
  - kw_done stays 0 throughout.
- Byte order: st_data = 128'h000102030405060708090a0b0c0d0e0f.
  - Expect st_result = 128'h637c777bf26b6fc53001672bfed7ab76.
- Key word (FIPS-197 RotWord): kw_data = 32'hcf4f3c09.
  - Expect kw_done in the 5th cycle after acceptance, with kw_result = 32'h8a84eb01.
  - busy high for exactly 4 cycles.
- RR tie after reset: st_valid and kw_valid both held high, st_data = 0, kw_data = 0.
  - Key is accepted first, kw_done = 1 with kw_result = 32'h63636363.
  - State is accepted at the next edge; st_done follows 17 cycles later.
  - With both valid still held, the third grant goes to key.
  - With RR_EN = 0, key wins every tie.
- Reset mid-run: reset for one cycle while the state op is at counter = 7.
  - Expect no st_done, st_result = 0, busy = 0.
  - A still-valid request is accepted on the first edge after reset release.
- Data stability: change st_data during ST_RUN.
  - The result reflects only the value sampled at acceptance.
